// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the single-port Mem block between the instruction-fetch port (if_*,
// read-only) and the load/store port (ls_*, read/write). Only one access is in
// flight at a time. Each access goes through IDLE -> ISSUE -> [WAIT] -> RESP.
// Misaligned requests go straight from IDLE to RESP with an error, and memory
// is not touched.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : when both ports request together, the grant goes to the port
//               that was not served last (rr_last resets to IF, so the first
//               tie goes to LS)
//   undefined : fixed priority, LS always wins a tie (IF may starve)
//
// Ports
//   sys_clk, sys_rst            clock (rising edge), async active-low reset
//   if_req_valid/ready/addr     fetch request handshake
//   if_rsp_valid/ready/rdata/err fetch response handshake
//   ls_req_valid/ready/rw/addr/wdata  load/store request (rw=1 is a write)
//   ls_rsp_valid/ready/rdata/err      load/store response
//   mem_op/rw/addr/data_w       one-cycle access strobe and command to Mem
//   mem_data_r                  Mem read data, valid RD_LATENCY cycles after op
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  input  logic                  if_rsp_ready,
  output logic [DATA_WIDTH-1:0] if_rsp_rdata,
  output logic                  if_rsp_err,

  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic                  ls_req_rw,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_rsp_valid,
  input  logic                  ls_rsp_ready,
  output logic [DATA_WIDTH-1:0] ls_rsp_rdata,
  output logic                  ls_rsp_err,

  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  localparam int ALIGN_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W       = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  logic [1:0]            state;
  logic                  grant;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt;

  logic                  pick_ls;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_rw;
  logic                  misaligned;
  logic                  rsp_hs;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  rr_last;
`endif

  // Winner selection: pick_ls is only meaningful while some request is valid.
  always_comb begin
    pick_ls = ls_req_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ls_req_valid && if_req_valid) begin
      pick_ls = (rr_last == PORT_IF);
    end
`endif
  end

  // Ready is gated by reset so every output reads 0 while reset is held,
  // even though ready is otherwise combinational from the request valids.
  assign accept       = sys_rst & (state == ST_IDLE) & (if_req_valid | ls_req_valid);
  assign ls_req_ready = accept & pick_ls;
  assign if_req_ready = accept & ~pick_ls;

  assign sel_addr   = pick_ls ? ls_req_addr : if_req_addr;
  assign sel_rw     = pick_ls & ls_req_rw;
  assign misaligned = ((sel_addr % ADDR_WIDTH'(ALIGN_BYTES)) != '0);

  assign rsp_hs = (grant == PORT_LS) ? ls_rsp_ready : if_rsp_ready;

  // Main sequencer: latches the accepted request, strobes Mem once, waits out
  // the read latency and holds the response until the requester takes it.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= ST_IDLE;
      grant   <= PORT_IF;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last <= PORT_IF;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant   <= pick_ls;
            rw_q    <= sel_rw;
            addr_q  <= sel_addr;
            wdata_q <= pick_ls ? ls_req_wdata : '0;
            rdata_q <= '0;
            err_q   <= misaligned;
            state   <= misaligned ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rw_q) begin
            state <= ST_RESP;
          end else if (RD_LATENCY == 0) begin
            rdata_q <= mem_data_r;
            state   <= ST_RESP;
          end else begin
            cnt   <= CNT_W'(RD_LATENCY);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            rdata_q <= mem_data_r;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_hs) begin
            state <= ST_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last <= grant;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_op     = (state == ST_ISSUE);
  assign mem_rw     = rw_q;
  assign mem_addr   = addr_q;
  assign mem_data_w = wdata_q;

  // Response data and error are shown only on the granted port.
  assign if_rsp_valid = (state == ST_RESP) && (grant == PORT_IF);
  assign ls_rsp_valid = (state == ST_RESP) && (grant == PORT_LS);
  assign if_rsp_rdata = (grant == PORT_IF) ? rdata_q : '0;
  assign ls_rsp_rdata = (grant == PORT_LS) ? rdata_q : '0;
  assign if_rsp_err   = (grant == PORT_IF) & err_q;
  assign ls_rsp_err   = (grant == PORT_LS) & err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port `Mem` block. It shares that memory between the instruction-fetch requester (`if_*`, read-only) and the load/store requester (`ls_*`, read/write). Each port uses a valid/ready request and response handshake. The block drives `Mem`'s `op`/`rw`/`addr`/`data_w` for exactly one cycle per access and captures `data_r` after a fixed read latency. Misaligned requests are rejected without touching memory.

## Interface
- `ADDR_WIDTH`, 32, address width in bits
- `DATA_WIDTH`, 32, data word width in bits
- `BYTE_WIDTH`, 8, bits per byte; word alignment = `DATA_WIDTH/BYTE_WIDTH` bytes
- `RD_LATENCY`, 1, cycles from the `op` cycle until `data_r` is valid (0 = combinational read)
- `sys_clk`  in  1  system clock, all logic on rising edge
- `sys_rst`  in  1  asynchronous, active-low reset
- `if_req_valid`  in  1  / `if_req_ready`  out  1 / `if_req_addr`  in  ADDR_WIDTH
- `if_rsp_valid`  out  1 / `if_rsp_ready`  in  1 / `if_rsp_rdata`  out  DATA_WIDTH / `if_rsp_err`  out  1
- `ls_req_valid`  in  1 / `ls_req_ready`  out  1 / `ls_req_rw`  in  1 (1 = write) / `ls_req_addr`  in  ADDR_WIDTH / `ls_req_wdata`  in  DATA_WIDTH
- `ls_rsp_valid`  out  1 / `ls_rsp_ready`  in  1 / `ls_rsp_rdata`  out  DATA_WIDTH / `ls_rsp_err`  out  1
- `mem_op`  out  1 / `mem_rw`  out  1 / `mem_addr`  out  ADDR_WIDTH / `mem_data_w`  out  DATA_WIDTH / `mem_data_r`  in  DATA_WIDTH

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE; all outputs are 0; `rr_last` = IF.
- **IDLE**
  - If any `*_req_valid`, pick a winner and assert that port's `*_req_ready` combinationally in the same cycle.
  - On handshake, latch grant, rw (IF always 0), addr and wdata.
  - If `addr % (DATA_WIDTH/BYTE_WIDTH) != 0`, go to RESP with err=1 and rdata=0. Otherwise go to ISSUE.
  - The loser's `req_ready` stays 0. Its request must hold until granted.
- **ISSUE**
  - `mem_op`=1 for exactly one cycle; `mem_rw`/`mem_addr`/`mem_data_w` come from latches.
  - Write goes to RESP.
  - Read with `RD_LATENCY`=0: sample `mem_data_r` at the end of this cycle, then go to RESP.
  - Read with `RD_LATENCY`>0: go to WAIT with counter = `RD_LATENCY`.
- **WAIT**
  - `mem_op`=0; decrement counter each cycle.
  - On the cycle the counter is 1, sample `mem_data_r` into the rdata register and go to RESP.
- **RESP**
  - Granted port's `rsp_valid`=1, with rdata (0 for writes) and err held stable until `rsp_ready`.
  - On handshake, go to IDLE and update `rr_last` = granted port.
- **Invariants**
  - `mem_op` is 0 in every state but ISSUE.
  - `*_req_ready` is 0 outside IDLE; only one access is in flight.
  - Each `*_rsp_valid` is asserted only for the granted port.
- **Reset mid-operation:** return immediately to IDLE and drop all valids and `mem_op`. A pending access is lost; a write already issued stays committed.

## Timing
- Request accepted in cycle N.
  - Aligned access: `mem_op` high in N+1.
  - Write: `rsp_valid` from N+2.
  - Read: `rsp_valid` from N+2+`RD_LATENCY`.
  - Misaligned access: `rsp_valid` from N+1, no `mem_op`.
- Best-case back-to-back throughput is one access per 3+`RD_LATENCY` cycles (write: 3). A new request can be accepted in the cycle after the response handshake.
- `rsp_ready` held low stalls in RESP indefinitely and all response outputs stay stable.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, grant the port opposite `rr_last`.
  - Reset value `rr_last`=IF, so the first tie goes to LS.
- Undefined:
  - Fixed priority: LS always wins ties and IF may starve.
  - `rr_last` logic is not built.

## Test plan
- **Aligned LS write then read, `RD_LATENCY`=1:** LS writes 0xDEADBEEF to addr 0x10, then reads addr 0x10.
  - Write: `mem_op`=1 with `mem_rw`=1 one cycle after accept; `ls_rsp_valid` at N+2 with err=0.
  - Read: `ls_rsp_rdata`=0xDEADBEEF at N+3.
- **Batch IF fetch:** LS writes i to addr 4·i for i=0..7; IF then reads them back.
  - Each `if_rsp_rdata` = i, err=0.
  - `ls_rsp_valid` never asserts during the IF reads.
- **Misaligned:** LS writes addr 0x6.
  - `ls_rsp_valid` at N+1 with err=1.
  - `mem_op` stays 0; a later read of 0x4 returns the old value.
- **Tie with `MEM_ARB_ROUND_ROBIN_EN`:** both ports hold valid continuously.
  - Grants alternate LS, IF, LS, IF.
  - Without the macro, only LS is granted until it drops valid.
- **Backpressure:** `ls_rsp_ready` held 0 for 10 cycles after a read of 0x10.
  - `rsp_valid`/rdata stay stable through the stall.
  - `if_req_ready`=0 throughout and `mem_op` stays 0.
- **Reset mid-read:** assert `sys_rst`=0 during WAIT.
  - All outputs go to 0 asynchronously.
  - After release the FSM is in IDLE and the next request completes normally.
